// File: rtl/dr_pkg.sv
// Shared types and width helpers for the multi-channel data-ready controller.
package dr_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_MOD, ASSERT, GAP} state_type;

  // Counters and selects never collapse to zero width, even for a count of 1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dr_chan_counter.sv
// Per-channel rising-edge detect, saturating pending-event counter and sticky overflow.
module dr_chan_counter #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dr,
  input  logic dec,
  input  logic clear_ovf,
  output logic pending_nz,
  output logic overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              dr_prev;
  logic [PEND_W-1:0] pend;
  logic              evt;
  logic              sat;

  assign evt = dr & ~dr_prev;
  // An event that coincides with a decrement cancels out, so it can never overflow.
  assign sat = evt && !dec && (pend == PEND_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dr_prev  <= 1'b0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      dr_prev <= dr;
      if (evt && !dec && !sat)
        pend <= pend + PEND_W'(1);
      else if (!evt && dec && (pend != '0))
        pend <= pend - PEND_W'(1);
      if (sat)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  assign pending_nz = |pend;

endmodule

// File: rtl/dr_multi_controller.sv
// Round-robin server of queued data-ready events: waits for modwait low, then
// drives a registered PULSE_LEN-cycle data_ready tagged with the channel index.
module dr_multi_controller
  import dr_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int PULSE_LEN = 3,
  parameter  int PEND_W    = 2,
  localparam int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] dr,
  input  logic              modwait,
  input  logic              clear_ovf,
  output logic              data_ready,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow
);

  localparam int              CNT_W    = clog2_min1(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CH_W-1:0]  RR_INIT  = CH_W'(NUM_CH - 1);

  state_type         state, nstate;
  logic [NUM_CH-1:0] pend_nz;
  logic [NUM_CH-1:0] dec;
  logic [CH_W-1:0]   rr, pick, cand;
  logic              found;
  logic [CNT_W-1:0]  pcnt;
  logic              last;
  int                idx;

  assign last = (state == ASSERT) && (pcnt == '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign dec[i] = last && (ch_sel == CH_W'(i));
    dr_chan_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk        (clk),
      .n_rst      (n_rst),
      .dr         (dr[i]),
      .dec        (dec[i]),
      .clear_ovf  (clear_ovf),
      .pending_nz (pend_nz[i]),
      .overflow   (overflow[i])
    );
  end

  // First pending channel after the last served one, wrapping at NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(rr) + k) % NUM_CH;
      cand = CH_W'(idx);
      if (!found && pend_nz[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (found)      nstate = WAIT_MOD;
      WAIT_MOD: if (!modwait)   nstate = ASSERT;
      ASSERT:   if (pcnt == '0) nstate = GAP;
      GAP:                      nstate = IDLE;
      default:                  nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready <= 1'b0;
      ch_sel     <= '0;
      rr         <= RR_INIT;
      pcnt       <= '0;
    end else begin
      data_ready <= (nstate == ASSERT);
      if (state == IDLE && found) begin
        ch_sel <= pick;
        rr     <= pick;
      end
      if (state == WAIT_MOD)
        pcnt <= CNT_LOAD;
      else if (state == ASSERT && pcnt != '0)
        pcnt <= pcnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dr_multi_controller.sv
// Directed bench: expected pulses queued by stimulus, checked by a negedge monitor.
module tb_dr_multi_controller;

  typedef struct {int ch; int len;} exp_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] dr;
  logic       modwait, clear_ovf;
  logic       data_ready, busy;
  logic [1:0] ch_sel;
  logic [3:0] overflow;

  logic       dr1;
  logic       data_ready1, busy1, ch_sel1, overflow1;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dr_multi_controller #(.NUM_CH(4), .PULSE_LEN(3), .PEND_W(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .dr(dr), .modwait(modwait), .clear_ovf(clear_ovf),
    .data_ready(data_ready), .ch_sel(ch_sel), .busy(busy), .overflow(overflow)
  );

  dr_multi_controller #(.NUM_CH(1), .PULSE_LEN(1), .PEND_W(2)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .dr(dr1), .modwait(1'b0), .clear_ovf(1'b0),
    .data_ready(data_ready1), .ch_sel(ch_sel1), .busy(busy1), .overflow(overflow1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int len);
    exp_t e;
    e.ch  = ch;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    repeat (8) step();
    chk({nm, " queue"}, exp_q.size(), 0);
    chk({nm, " idle"}, busy, 0);
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  // Monitor: measure each data_ready run and compare against the queue head.
  logic mon_hi = 1'b0;
  int   run_len, run_ch;
  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      mon_hi = 1'b0;
    end else if (data_ready && !mon_hi) begin
      mon_hi  = 1'b1;
      run_len = 1;
      run_ch  = int'(ch_sel);
    end else if (data_ready) begin
      run_len++;
    end else if (mon_hi) begin
      mon_hi = 1'b0;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse unexpected: got ch %0d len %0d expected none", run_ch, run_len);
      end else begin
        e = exp_q.pop_front();
        if (e.ch != run_ch || e.len != run_len) begin
          fails++;
          $display("FAIL pulse: got ch %0d len %0d expected ch %0d len %0d",
                   run_ch, run_len, e.ch, e.len);
        end
      end
    end
  end

  initial begin
    logic hi;
    n_rst = 1'b0; dr = '0; modwait = 1'b0; clear_ovf = 1'b0; dr1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst data_ready", data_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst ch_sel", ch_sel, 0);
    chk("rst overflow", overflow, 0);
    n_rst = 1'b1;
    step();

    // single event latency
    push(0, 3);
    dr[0] = 1'b1;
    step(); chk("t1 k busy", busy, 0);
    step(); chk("t1 k+1 busy", busy, 1); chk("t1 k+1 dr", data_ready, 0); chk("t1 ch_sel", ch_sel, 0);
    step(); chk("t1 k+2 dr", data_ready, 1);
    step(); step(); chk("t1 k+4 dr", data_ready, 1);
    step(); chk("t1 k+5 dr", data_ready, 0); chk("t1 k+5 busy", busy, 1);
    step(); chk("t1 k+6 busy", busy, 0);
    dr[0] = 1'b0;
    drain("t1");

    // modwait hold, then modwait pulse during ASSERT
    modwait = 1'b1;
    dr[2] = 1'b1;
    push(2, 3);
    hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) dr[2] = 1'b0;
      if (data_ready) hi = 1'b1;
    end
    chk("t2 held low", hi, 0);
    chk("t2 ch_sel", ch_sel, 2);
    modwait = 1'b0;
    step(); chk("t2 rise", data_ready, 1);
    modwait = 1'b1;
    step();
    modwait = 1'b0;
    drain("t2");

    // round robin with wrap
    reset_dut();
    dr[1] = 1'b1; dr[3] = 1'b1;
    push(1, 3); push(3, 3);
    step();
    dr[1] = 1'b0; dr[3] = 1'b0;
    step(); step();
    dr[0] = 1'b1;
    push(0, 3);
    step();
    dr[0] = 1'b0;
    drain("t3");

    // saturate pending and overflow
    modwait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dr[0] = 1'b1; step();
      dr[0] = 1'b0; step();
    end
    chk("t4 overflow set", overflow, 4'b0001);
    push(0, 3); push(0, 3); push(0, 3);
    modwait = 1'b0;
    drain("t4");
    chk("t4 overflow sticky", overflow, 4'b0001);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    chk("t4 overflow clear", overflow, 0);

    // increment and decrement in the same cycle
    dr[1] = 1'b1;
    push(1, 3); push(1, 3);
    step();
    dr[1] = 1'b0;
    step(); step(); step(); step();
    dr[1] = 1'b1;
    step();
    dr[1] = 1'b0;
    drain("t5");
    chk("t5 overflow", overflow, 0);

    // async reset during ASSERT
    modwait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dr[2] = 1'b1; step();
      dr[2] = 1'b0; step();
    end
    modwait = 1'b0;
    step();
    chk("t6 pre dr", data_ready, 1);
    chk("t6 pre ovf", overflow, 4'b0100);
    chk("t6 pre ch_sel", ch_sel, 2);
    #2 n_rst = 1'b0;
    #1;
    chk("t6 rst dr", data_ready, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst ovf", overflow, 0);
    chk("t6 rst ch_sel", ch_sel, 0);
    step(); step();
    n_rst = 1'b1;
    hi = 1'b0;
    repeat (20) begin
      step();
      if (data_ready || busy) hi = 1'b1;
    end
    chk("t6 quiet", hi, 0);

    // single-channel, 1-cycle pulse variant
    dr1 = 1'b1;
    step(); chk("t7 k busy", busy1, 0);
    dr1 = 1'b0;
    step(); chk("t7 k+1 busy", busy1, 1); chk("t7 k+1 dr", data_ready1, 0);
    step(); chk("t7 k+2 dr", data_ready1, 1); chk("t7 ch_sel", ch_sel1, 0);
    step(); chk("t7 k+3 dr", data_ready1, 0); chk("t7 k+3 busy", busy1, 1);
    step(); chk("t7 k+4 busy", busy1, 0);
    chk("t7 overflow", overflow1, 0);

    chk("final queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
